// File: rtl/retire_checker_pkg.sv
// Shared encodings for the retire checker: op classes, fail causes, record layout, FSM states.
package retire_checker_pkg;

  typedef enum logic [3:0] {
    OP_SUB  = 4'd0,
    OP_MOVL = 4'd1,
    OP_MOVH = 4'd2,
    OP_LD   = 4'd3,
    OP_ST   = 4'd4,
    OP_JZ   = 4'd5,
    OP_JNZ  = 4'd6,
    OP_JS   = 4'd7,
    OP_JNS  = 4'd8,
    OP_END  = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_MISMATCH     = 3'd1,
    FC_OVERFLOW     = 3'd2,
    FC_EXTRA_RETIRE = 3'd3,
    FC_SHORT_TRACE  = 3'd4
  } fail_code_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_COMPARE = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  localparam int REC_W    = 52;
  localparam int OP_LSB   = 48;
  localparam int PC_LSB   = 32;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 0;

  // Field order mirrors the offsets above: op in the top nibble, data in the low word.
  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
  } rec_t;

  function automatic logic is_jump(input logic [3:0] op);
    return (op >= 4'(OP_JZ)) && (op <= 4'(OP_JNS));
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// Synchronous FIFO buffering retire events until their expected record arrives.
module retire_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 52
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/retire_checker.sv
// Compares the CPU retire stream against an expected trace fetched one record at a time.
module retire_checker
  import retire_checker_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TRACE_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        retired,
  input  logic [3:0]  ret_op,
  input  logic [15:0] ret_pc,
  input  logic [15:0] ret_addr,
  input  logic [15:0] ret_data,
  input  logic        halt,
  output logic        exp_req,
  output logic [15:0] exp_addr,
  input  logic        exp_ack,
  input  logic [51:0] exp_rdata,
  output logic [15:0] match_count,
  output logic        done,
  output logic        fail,
  output logic [2:0]  fail_code,
  output logic [15:0] fail_index
);

  state_e     state_q, state_d;
  fail_code_e fail_code_q, fail_code_d;
  logic       halt_q;
  logic [15:0] match_count_q, match_count_d;
  logic [15:0] fail_index_q, fail_index_d;
  logic [15:0] cur_index;
  rec_t       rec_q, rec_d;
  rec_t       head;
  logic [REC_W-1:0] head_raw;
  logic       fifo_full, fifo_empty;
  logic       push, pop, active, overflow, fields_eq;

  retire_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({ret_op, ret_pc, ret_addr, ret_data}),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head      = rec_t'(head_raw);
  assign cur_index = TRACE_BASE + match_count_q;
  assign active    = (state_q != ST_DONE) && (state_q != ST_FAIL);
  // Jump destinations carry no architectural address, so addr is only checked for other ops.
  assign fields_eq = (head.op == rec_q.op) && (head.pc == rec_q.pc) &&
                     (head.data == rec_q.data) &&
                     (is_jump(rec_q.op) || (head.addr == rec_q.addr));

  always_comb begin
    state_d       = state_q;
    match_count_d = match_count_q;
    fail_code_d   = fail_code_q;
    fail_index_d  = fail_index_q;
    rec_d         = rec_q;
    pop           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || halt_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (exp_ack) begin
          rec_d   = rec_t'(exp_rdata);
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (!fifo_empty) begin
          if (rec_q.op == 4'(OP_END)) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_EXTRA_RETIRE;
          end else if (fields_eq) begin
            pop     = 1'b1;
            state_d = ST_IDLE;
            if (match_count_q != 16'hFFFF) match_count_d = match_count_q + 16'd1;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = FC_MISMATCH;
          end
        end else if (halt_q) begin
          if (rec_q.op == 4'(OP_END)) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = FC_SHORT_TRACE;
          end
        end
      end
      default: ;
    endcase
    if (overflow) begin
      state_d     = ST_FAIL;
      fail_code_d = FC_OVERFLOW;
    end
    if (state_d == ST_FAIL && state_q != ST_FAIL) fail_index_d = cur_index;
  end

  assign overflow = retired && active && fifo_full && !pop;
  assign push     = retired && active && !overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      halt_q        <= 1'b0;
      match_count_q <= '0;
      fail_code_q   <= FC_NONE;
      fail_index_q  <= '0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_q | halt;
      match_count_q <= match_count_d;
      fail_code_q   <= fail_code_d;
      fail_index_q  <= fail_index_d;
    end
  end

  always_ff @(posedge clk) begin
    rec_q <= rec_d;
  end

  assign exp_req     = (state_q == ST_FETCH);
  assign exp_addr    = exp_req ? cur_index : 16'h0000;
  assign match_count = match_count_q;
  assign done        = (state_q == ST_DONE);
  assign fail        = (state_q == ST_FAIL);
  assign fail_code   = fail_code_q;
  assign fail_index  = fail_index_q;

endmodule

// File: tb/tb_retire_checker.sv
// Scoreboard bench: each scenario queues its expected end state; a monitor checks it on done/fail.
module tb_retire_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        retired = 1'b0;
  logic [3:0]  ret_op = '0;
  logic [15:0] ret_pc = '0, ret_addr = '0, ret_data = '0;
  logic        halt = 1'b0;
  logic        exp_req;
  logic [15:0] exp_addr;
  logic        exp_ack = 1'b0;
  logic [51:0] exp_rdata = '0;
  logic [15:0] match_count;
  logic        done, fail;
  logic [2:0]  fail_code;
  logic [15:0] fail_index;

  retire_checker #(.FIFO_DEPTH(4), .TRACE_BASE(16'h0000)) dut (
    .clk(clk), .reset(reset), .retired(retired), .ret_op(ret_op), .ret_pc(ret_pc),
    .ret_addr(ret_addr), .ret_data(ret_data), .halt(halt), .exp_req(exp_req),
    .exp_addr(exp_addr), .exp_ack(exp_ack), .exp_rdata(exp_rdata),
    .match_count(match_count), .done(done), .fail(fail), .fail_code(fail_code),
    .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        done;
    logic        fail;
    logic [2:0]  code;
    logic [15:0] idx;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_seen = 0;
  int          lat = 3;
  logic [51:0] mem [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Trace memory responder: acks each request after lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_req) begin
        logic [15:0] a;
        a = exp_addr;
        repeat (lat - 1) @(negedge clk);
        exp_rdata = mem[a[3:0]];
        exp_ack = 1'b1;
        @(negedge clk);
        exp_ack = 1'b0;
      end
    end
  end

  // Monitor: pops one expectation whenever the DUT reaches a terminal state.
  initial begin
    logic reported;
    exp_t e;
    reported = 1'b0;
    forever begin
      @(negedge clk);
      if (!(done || fail)) reported = 1'b0;
      else if (!reported) begin
        reported = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_end: done=%0b fail=%0b code=%0d", done, fail, fail_code);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("t%0d_done", e.id), 32'(done), 32'(e.done));
          check($sformatf("t%0d_fail", e.id), 32'(fail), 32'(e.fail));
          check($sformatf("t%0d_code", e.id), 32'(fail_code), 32'(e.code));
          check($sformatf("t%0d_index", e.id), 32'(fail_index), 32'(e.idx));
          check($sformatf("t%0d_count", e.id), 32'(match_count), 32'(e.cnt));
        end
        n_seen++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    retired = 1'b0;
    halt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ret(input logic [3:0] op, input logic [15:0] pc, input logic [15:0] ad,
                     input logic [15:0] da, input logic h);
    retired = 1'b1;
    ret_op = op; ret_pc = pc; ret_addr = ad; ret_data = da;
    halt = h;
    @(negedge clk);
    retired = 1'b0;
    halt = 1'b0;
  endtask

  task automatic expect_end(input int id, input logic d, input logic f, input logic [2:0] c,
                            input logic [15:0] ix, input logic [15:0] cn);
    exp_t e;
    e.id = id; e.done = d; e.fail = f; e.code = c; e.idx = ix; e.cnt = cn;
    exp_q.push_back(e);
  endtask

  task automatic wait_end(input int id, input int start);
    int k;
    k = 0;
    while (n_seen == start && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (n_seen == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL t%0d_timeout: no terminal state after %0d cycles", id, k);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic load_basic(input logic [15:0] st_data);
    for (int i = 0; i < 16; i++) mem[i] = {4'd15, 48'h0};
    mem[0] = {4'd1, 16'h0000, 16'h0001, 16'h0012};
    mem[1] = {4'd4, 16'h0001, 16'h0010, st_data};
  endtask

  initial begin
    int s;
    int k;
    // Reset values
    @(negedge clk);
    do_reset();
    check("rst_exp_req", 32'(exp_req), 0);
    check("rst_exp_addr", 32'(exp_addr), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_code", 32'(fail_code), 0);
    check("rst_index", 32'(fail_index), 0);

    // 1: clean two-record trace, halt on the last retire
    lat = 3;
    load_basic(16'h0012);
    s = n_seen;
    expect_end(1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'd2);
    ret(4'd1, 16'h0000, 16'h0001, 16'h0012, 1'b0);
    ret(4'd4, 16'h0001, 16'h0010, 16'h0013 - 16'h0001, 1'b1);
    wait_end(1, s);

    // 2: store data mismatch on the second record
    do_reset();
    load_basic(16'h0012);
    s = n_seen;
    expect_end(2, 1'b0, 1'b1, 3'd1, 16'h0001, 16'd1);
    ret(4'd1, 16'h0000, 16'h0001, 16'h0012, 1'b0);
    ret(4'd4, 16'h0001, 16'h0010, 16'h0013, 1'b1);
    wait_end(2, s);

    // 3: six back-to-back retires with slow acks overflow on the fifth push
    do_reset();
    lat = 10;
    for (int i = 0; i < 16; i++) mem[i] = {4'd0, 16'(i), 16'h0001, 16'h0000};
    s = n_seen;
    expect_end(3, 1'b0, 1'b1, 3'd2, 16'h0000, 16'd0);
    for (int i = 0; i < 6; i++) ret(4'd0, 16'(i), 16'h0001, 16'h0000, 1'b0);
    wait_end(3, s);

    // 4: jump record matches despite differing addr
    do_reset();
    lat = 2;
    for (int i = 0; i < 16; i++) mem[i] = {4'd15, 48'h0};
    mem[0] = {4'd5, 16'h0004, 16'h0000, 16'h0008};
    s = n_seen;
    expect_end(4, 1'b1, 1'b0, 3'd0, 16'h0000, 16'd1);
    ret(4'd5, 16'h0004, 16'hABCD, 16'h0008, 1'b1);
    wait_end(4, s);

    // 5: trace longer than retire stream
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = {4'd15, 48'h0};
    mem[0] = {4'd0, 16'h0000, 16'h0002, 16'h0005};
    mem[1] = {4'd3, 16'h0001, 16'h0003, 16'h0007};
    mem[2] = {4'd6, 16'h0002, 16'h0000, 16'h0000};
    s = n_seen;
    expect_end(5, 1'b0, 1'b1, 3'd4, 16'h0002, 16'd2);
    ret(4'd0, 16'h0000, 16'h0002, 16'h0005, 1'b0);
    ret(4'd3, 16'h0001, 16'h0003, 16'h0007, 1'b1);
    wait_end(5, s);

    // 6: retire stream longer than trace
    do_reset();
    s = n_seen;
    expect_end(6, 1'b0, 1'b1, 3'd3, 16'h0003, 16'd3);
    ret(4'd0, 16'h0000, 16'h0002, 16'h0005, 1'b0);
    ret(4'd3, 16'h0001, 16'h0003, 16'h0007, 1'b0);
    ret(4'd6, 16'h0002, 16'h1111, 16'h0000, 1'b0);
    ret(4'd0, 16'h0003, 16'h0001, 16'h0009, 1'b1);
    wait_end(6, s);

    // 7: reset while a request is outstanding, ack lands one cycle later
    do_reset();
    lat = 2;
    ret(4'd0, 16'h0000, 16'h0002, 16'h0005, 1'b0);
    k = 0;
    while (!exp_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t7_req_seen", 32'(exp_req), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t7_exp_req", 32'(exp_req), 0);
    check("t7_exp_addr", 32'(exp_addr), 0);
    check("t7_count", 32'(match_count), 0);
    check("t7_done", 32'(done), 0);
    check("t7_fail", 32'(fail), 0);
    check("t7_code", 32'(fail_code), 0);
    check("t7_index", 32'(fail_index), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_checker.md
RETIRE_CHECKER -- requirements
Module: retire_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, retire-event buffer depth; power of two, 2..16.
REQ-002 Parameter TRACE_BASE, default 16'h0000, word index of the first expected record.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 retired  in  1  one instruction retires this cycle.
REQ-006 ret_op  in  4  retired-op class (package encoding).
REQ-007 ret_pc  in  16  PC of the retired instruction.
REQ-008 ret_addr  in  16  destination: register index (zero-extended) for sub/movl/movh/ld, memory address for st, don't-care for jumps.
REQ-009 ret_data  in  16  register write data, store data, or jump target.
REQ-010 halt  in  1  CPU halted; no further retire after this cycle.
REQ-011 exp_req  out  1  expected-record read request, held until exp_ack.
REQ-012 exp_addr  out  16  record index requested.
REQ-013 exp_ack  in  1  one-cycle response strobe, latency >= 1 cycle after exp_req.
REQ-014 exp_rdata  in  52  expected record {op[51:48], pc[47:32], addr[31:16], data[15:0]}.
REQ-015 match_count  out  16  records matched so far.
REQ-016 done  out  1  sticky: trace fully matched and ended correctly.
REQ-017 fail  out  1  sticky: mismatch, overflow, or length error.
REQ-018 fail_code  out  3  cause of fail (package encoding).
REQ-019 fail_index  out  16  record index at which fail occurred.

Function
REQ-020 Each cycle with retired=1 shall push {op,pc,addr,data} into the FIFO, except in DONE or FAIL.
REQ-021 retired=1 with the FIFO full and no pop in the same cycle shall enter FAIL with code OVERFLOW; a simultaneous push and pop on a full FIFO shall be legal.
REQ-022 States: IDLE, FETCH, COMPARE, DONE, FAIL.
REQ-023 IDLE -> FETCH when the FIFO is non-empty or halt is latched; exp_req=1 and exp_addr=TRACE_BASE+match_count in FETCH.
REQ-024 FETCH -> COMPARE on exp_ack; exp_rdata shall be registered on that cycle; exp_req deasserts the cycle after exp_ack.
REQ-025 In COMPARE, if the FIFO is non-empty and the record op is not END: compare op, pc, data always; compare addr only for non-jump ops; on equality pop the FIFO, increment match_count, and go to IDLE.
REQ-026 An op, pc, addr, or data mismatch shall enter FAIL with code MISMATCH; the FIFO head is not popped.
REQ-027 A record op of END with a non-empty FIFO shall enter FAIL with code EXTRA_RETIRE.
REQ-028 A record op of END with the FIFO empty and halt latched shall enter DONE.
REQ-029 With the FIFO empty and halt latched, a record op other than END shall enter FAIL with code SHORT_TRACE.
REQ-030 In COMPARE with the FIFO empty and halt not latched, the record shall be held until an event arrives.
REQ-031 halt shall be latched sticky; retired and halt in the same cycle shall push the event first.
REQ-032 match_count shall saturate at 16'hFFFF.
REQ-033 fail_index shall equal TRACE_BASE+match_count at fail entry, with 16-bit wrap.
REQ-034 DONE and FAIL are terminal until reset; exp_req=0 in both states.
REQ-035 An exp_ack outside FETCH shall be ignored.

Reset
REQ-036 Reset shall set: state IDLE, FIFO empty, halt latch 0, exp_req 0, exp_addr 0, match_count 0, done 0, fail 0, fail_code 0, fail_index 0.
REQ-037 Reset asserted mid-FETCH shall abandon the request; a later exp_ack shall be ignored per REQ-035.

Structure
REQ-038 A shared package shall hold the op encoding (SUB=0, MOVL=1, MOVH=2, LD=3, ST=4, JZ=5, JNZ=6, JS=7, JNS=8, END=15), the fail_code encoding (NONE=0, MISMATCH=1, OVERFLOW=2, EXTRA_RETIRE=3, SHORT_TRACE=4), the record field offsets, and the state enum.
REQ-039 The event buffer shall be one sub-module, retire_fifo: a synchronous FIFO with push/pop/full/empty.

Verification
REQ-040 Records movl r1=0012 @0000, st m[0010]=0012 @0001, END; matching retires then halt, 3-cycle ack latency -> done=1, match_count=2, fail=0.
REQ-041 Second retire has data 0013 vs expected 0012 -> fail=1, fail_code=1, fail_index=0001, match_count=1.
REQ-042 Six back-to-back retires with FIFO_DEPTH=4 and 10-cycle ack latency -> fail_code=2 on the fifth push.
REQ-043 jz @0004 target 0008, retired ret_addr=ABCD vs record addr 0000 -> match (addr ignored), match_count increments.
REQ-044 Trace holds 3 records plus END; CPU retires 2 then halts -> fail_code=4, fail_index=0002; a second case with 4 retires -> fail_code=3, fail_index=0003.
REQ-045 Reset pulse while exp_req=1, with ack arriving the next cycle -> all outputs at reset values, state IDLE, ack ignored.
